// File: rtl/dcsk_rx_pkg.sv
// Shared types and helpers for the DCSK demodulator control unit.
// Spread-factor decoding lives here so the FSM and any future data-path code agree on it.
package dcsk_rx_pkg;

    localparam int FRAME_CHIPS_DEF = 64;

    typedef enum logic [2:0] {
        DS_IDLE  = 3'd0,
        DS_REF   = 3'd1,
        DS_DATA  = 3'd2,
        DS_FLUSH = 3'd3,
        DS_HOLD  = 3'd4
    } demod_state_t;

    // Unsupported spread factors fall back to the smallest legal one (2).
    function automatic logic [2:0] sf_to_log2(input logic [4:0] sf);
        logic [2:0] lg_s;
        case (sf)
            5'd2:    lg_s = 3'd1;
            5'd4:    lg_s = 3'd2;
            5'd8:    lg_s = 3'd3;
            5'd16:   lg_s = 3'd4;
            default: lg_s = 3'd1;
        endcase
        return lg_s;
    endfunction

    function automatic logic [3:0] sf_to_last(input logic [4:0] sf);
        logic [3:0] last_s;
        case (sf)
            5'd2:    last_s = 4'd1;
            5'd4:    last_s = 4'd3;
            5'd8:    last_s = 4'd7;
            5'd16:   last_s = 4'd15;
            default: last_s = 4'd1;
        endcase
        return last_s;
    endfunction

    // Bits per frame: one bit spans 2*SF chips.
    function automatic logic [4:0] sf_to_nbits(input logic [4:0] sf, input int frame_chips);
        return 5'(frame_chips >> (sf_to_log2(sf) + 3'd1));
    endfunction

endpackage

// File: rtl/dcsk_demod_ctrl.sv
// DCSK demodulator control: sequences reference/data half-bits, steers the bit decision
// into the serial-to-parallel register and hands finished frames out over valid/ready.
module dcsk_demod_ctrl
    import dcsk_rx_pkg::*;
#(
    parameter int FRAME_CHIPS = FRAME_CHIPS_DEF
) (
    input  logic       Clk,
    input  logic       N_Rst,
    input  logic       Frame_Start,
    input  logic       In_Valid,
    output logic       In_Ready,
    input  logic [4:0] Spread_Factor,
    input  logic       Correlated_Bit,
    output logic [3:0] Var_Del_Reg_Addr,
    output logic       Var_Del_Reg_Load,
    output logic       Var_Del_Reg_Re,
    output logic       Ones_Count_Inc,
    output logic       Zeros_Count_Inc,
    output logic       Ones_Zeros_Count_Clr,
    output logic       STP_Out_Reg_Load,
    output logic [4:0] STP_Out_Reg_Addr,
    output logic       STP_Out_Reg_Re,
    output logic       Out_Valid,
    input  logic       Out_Ready,
    output logic [4:0] Out_Bits
);

    localparam logic [2:0] S_IDLE  = DS_IDLE;
    localparam logic [2:0] S_REF   = DS_REF;
    localparam logic [2:0] S_DATA  = DS_DATA;
    localparam logic [2:0] S_FLUSH = DS_FLUSH;
    localparam logic [2:0] S_HOLD  = DS_HOLD;

    logic [2:0] state_r,     state_nxt_s;
    logic [3:0] chip_idx_r,  chip_idx_nxt_s;
    logic [4:0] bit_idx_r,   bit_idx_nxt_s;
    logic [3:0] sf_last_r,   sf_last_nxt_s;
    logic [4:0] nbits_r,     nbits_nxt_s;
    logic       wr_pend_r,   wr_pend_nxt_s;
    logic       in_ready_r;
    logic       out_valid_r;
    logic       stp_re_r;
    logic [4:0] out_bits_r;

    logic       acc_s;
    logic       start_s;
    logic       last_chip_s;
    logic       last_bit_s;
    logic       active_s;

    assign active_s    = (state_r == S_IDLE) || (state_r == S_REF) || (state_r == S_DATA);
    assign acc_s       = In_Valid & in_ready_r;
    assign start_s     = Frame_Start & active_s;
    assign last_chip_s = (chip_idx_r == sf_last_r);
    assign last_bit_s  = (bit_idx_r == (nbits_r - 5'd1));

    // Next-state logic; a Frame_Start while accepting chips always restarts the frame.
    always_comb begin
        state_nxt_s    = state_r;
        chip_idx_nxt_s = chip_idx_r;
        bit_idx_nxt_s  = bit_idx_r;
        sf_last_nxt_s  = sf_last_r;
        nbits_nxt_s    = nbits_r;
        wr_pend_nxt_s  = 1'b0;
        if (start_s) begin
            state_nxt_s    = S_REF;
            chip_idx_nxt_s = acc_s ? 4'd1 : 4'd0;
            bit_idx_nxt_s  = 5'd0;
            sf_last_nxt_s  = sf_to_last(Spread_Factor);
            nbits_nxt_s    = sf_to_nbits(Spread_Factor, FRAME_CHIPS);
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_nxt_s = S_IDLE;
                end
                S_REF: begin
                    if (acc_s && last_chip_s) begin
                        state_nxt_s    = S_DATA;
                        chip_idx_nxt_s = 4'd0;
                    end else if (acc_s) begin
                        chip_idx_nxt_s = chip_idx_r + 4'd1;
                    end else begin
                        chip_idx_nxt_s = chip_idx_r;
                    end
                end
                S_DATA: begin
                    if (acc_s && last_chip_s) begin
                        chip_idx_nxt_s = 4'd0;
                        if (last_bit_s) begin
                            state_nxt_s = S_FLUSH;
                        end else begin
                            state_nxt_s   = S_REF;
                            bit_idx_nxt_s = bit_idx_r + 5'd1;
                            wr_pend_nxt_s = 1'b1;
                        end
                    end else if (acc_s) begin
                        chip_idx_nxt_s = chip_idx_r + 4'd1;
                    end else begin
                        chip_idx_nxt_s = chip_idx_r;
                    end
                end
                S_FLUSH: begin
                    state_nxt_s = S_HOLD;
                end
                S_HOLD: begin
                    state_nxt_s = Out_Ready ? S_IDLE : S_HOLD;
                end
                default: begin
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

    // Data-path strobes; the pending bit write shares its cycle with the next reference chip.
    always_comb begin
        Var_Del_Reg_Addr     = 4'd0;
        Var_Del_Reg_Load     = 1'b0;
        Var_Del_Reg_Re       = 1'b0;
        Ones_Count_Inc       = 1'b0;
        Zeros_Count_Inc      = 1'b0;
        Ones_Zeros_Count_Clr = 1'b0;
        STP_Out_Reg_Load     = 1'b0;
        STP_Out_Reg_Addr     = 5'd0;
        if (start_s) begin
            Var_Del_Reg_Load     = acc_s;
            Ones_Zeros_Count_Clr = 1'b1;
        end else begin
            case (state_r)
                S_REF: begin
                    Var_Del_Reg_Addr     = chip_idx_r;
                    Var_Del_Reg_Load     = acc_s;
                    STP_Out_Reg_Load     = wr_pend_r;
                    STP_Out_Reg_Addr     = wr_pend_r ? (bit_idx_r - 5'd1) : 5'd0;
                    Ones_Zeros_Count_Clr = wr_pend_r;
                end
                S_DATA: begin
                    Var_Del_Reg_Addr = chip_idx_r;
                    Var_Del_Reg_Re   = 1'b1;
                    Ones_Count_Inc   = acc_s & Correlated_Bit;
                    Zeros_Count_Inc  = acc_s & ~Correlated_Bit;
                end
                S_FLUSH: begin
                    STP_Out_Reg_Load     = 1'b1;
                    STP_Out_Reg_Addr     = bit_idx_r;
                    Ones_Zeros_Count_Clr = 1'b1;
                end
                default: begin
                    Var_Del_Reg_Addr = 4'd0;
                end
            endcase
        end
    end

    // State, counters and handshake outputs.
    always_ff @(posedge Clk or negedge N_Rst) begin
        if (!N_Rst) begin
            state_r     <= S_IDLE;
            chip_idx_r  <= 4'd0;
            bit_idx_r   <= 5'd0;
            sf_last_r   <= sf_to_last(5'd2);
            nbits_r     <= sf_to_nbits(5'd2, FRAME_CHIPS);
            wr_pend_r   <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            stp_re_r    <= 1'b0;
            out_bits_r  <= 5'd0;
        end else begin
            state_r     <= state_nxt_s;
            chip_idx_r  <= chip_idx_nxt_s;
            bit_idx_r   <= bit_idx_nxt_s;
            sf_last_r   <= sf_last_nxt_s;
            nbits_r     <= nbits_nxt_s;
            wr_pend_r   <= wr_pend_nxt_s;
            in_ready_r  <= (state_nxt_s == S_IDLE) || (state_nxt_s == S_REF) ||
                           (state_nxt_s == S_DATA);
            out_valid_r <= (state_nxt_s == S_HOLD);
            stp_re_r    <= (state_nxt_s == S_HOLD);
            out_bits_r  <= (state_nxt_s == S_HOLD) ? nbits_nxt_s : 5'd0;
        end
    end

    assign In_Ready       = in_ready_r;
    assign Out_Valid      = out_valid_r;
    assign STP_Out_Reg_Re = stp_re_r;
    assign Out_Bits       = out_bits_r;

endmodule
